// File: rtl/tc_pl_bus_status_if.sv
// Bus bundle between the per-channel PL bus engines and the status/event block.
// The master side drives engine flags and register-file controls; the slave side reports status.
interface tc_pl_bus_status_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       tx_ting;
  logic [CH-1:0]       tx_cmpt;
  logic [CH-1:0]       txb_empty;
  logic [CH-1:0]       txb_full;
  logic [CH-1:0]       rxb_empty;
  logic [CH-1:0]       rxb_full;
  logic [CH-1:0]       sticky_clr;
  logic [CH-1:0]       cnt_clr;
  logic [2*CH-1:0]     irq_en;
  logic [8*CH-1:0]     state;
  logic [CNT_W*CH-1:0] cmpt_cnt;
  logic                irq;

  modport master (
    output tx_ting, tx_cmpt, txb_empty, txb_full, rxb_empty, rxb_full,
    output sticky_clr, cnt_clr, irq_en,
    input  state, cmpt_cnt, irq
  );

  modport slave (
    input  tx_ting, tx_cmpt, txb_empty, txb_full, rxb_empty, rxb_full,
    input  sticky_clr, cnt_clr, irq_en,
    output state, cmpt_cnt, irq
  );
endinterface

// File: rtl/tc_pl_bus_status.sv
// Multi-channel PL bus status: registered buffer levels, sticky completion/rx-full/overrun
// events, saturating completion counters and one maskable level interrupt.
module tc_pl_bus_status #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  tc_pl_bus_status_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CH-1:0] irq_src;
  logic          irq_reg;
  logic          irq_next;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic             cmpt_prev_reg;
    logic             rxf_prev_reg;
    logic [4:0]       lvl_reg;
    logic [4:0]       lvl_next;
    logic             cmpt_s_reg, cmpt_s_next;
    logic             rxf_s_reg, rxf_s_next;
    logic             ovr_s_reg, ovr_s_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cmpt_edge;
    logic             rxf_edge;
    logic             clr;

    assign cmpt_edge = bus.tx_cmpt[gi] & ~cmpt_prev_reg;
    assign rxf_edge  = bus.rxb_full[gi] & ~rxf_prev_reg;
    assign clr       = bus.sticky_clr[gi];

    always_comb begin
      lvl_next    = {bus.rxb_full[gi], ~bus.rxb_empty[gi], bus.txb_full[gi],
                     bus.txb_empty[gi], bus.tx_ting[gi]};
      // A new event wins over a same-cycle clear so it is never lost.
      cmpt_s_next = cmpt_edge | (cmpt_s_reg & ~clr);
      rxf_s_next  = rxf_edge  | (rxf_s_reg  & ~clr);
      ovr_s_next  = ((cmpt_edge & cmpt_s_reg) | ovr_s_reg) & ~clr;
      cnt_next    = cnt_reg;
      if (bus.cnt_clr[gi]) begin
        cnt_next = cmpt_edge ? CNT_ONE : '0;
      end else if (cmpt_edge && (cnt_reg != CNT_MAX)) begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cmpt_prev_reg <= 1'b0;
        rxf_prev_reg  <= 1'b0;
        lvl_reg       <= '0;
        cmpt_s_reg    <= 1'b0;
        rxf_s_reg     <= 1'b0;
        ovr_s_reg     <= 1'b0;
        cnt_reg       <= '0;
      end else begin
        cmpt_prev_reg <= bus.tx_cmpt[gi];
        rxf_prev_reg  <= bus.rxb_full[gi];
        lvl_reg       <= lvl_next;
        cmpt_s_reg    <= cmpt_s_next;
        rxf_s_reg     <= rxf_s_next;
        ovr_s_reg     <= ovr_s_next;
        cnt_reg       <= cnt_next;
      end
    end

    assign bus.state[8*gi +: 8]          = {ovr_s_reg, rxf_s_reg, lvl_reg, cmpt_s_reg};
    assign bus.cmpt_cnt[CNT_W*gi +: CNT_W] = cnt_reg;
    // Interrupt looks at the already-registered stickies, adding one cycle of latency.
    assign irq_src[gi] = (cmpt_s_reg & bus.irq_en[2*gi]) | (rxf_s_reg & bus.irq_en[2*gi+1]);
  end

  assign irq_next = |irq_src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= irq_next;
    end
  end

  assign bus.irq = irq_reg;

endmodule

// File: tb/tb_tc_pl_bus_status.sv
// Directed-vector bench for tc_pl_bus_status (4 channels, 3-bit counters).
module tb_tc_pl_bus_status;
  localparam int C = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  tc_pl_bus_status_if #(.CH(C), .CNT_W(W)) bus ();

  tc_pl_bus_status #(.CH(C), .CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tx_ting    = '0;
    bus.tx_cmpt    = '0;
    bus.txb_empty  = '0;
    bus.txb_full   = '0;
    bus.rxb_empty  = '1;
    bus.rxb_full   = '0;
    bus.sticky_clr = '0;
    bus.cnt_clr    = '0;
    bus.irq_en     = '0;
  endtask

  task automatic pulse(input int ch);
    bus.tx_cmpt[ch] = 1'b1;
    step();
    bus.tx_cmpt[ch] = 1'b0;
    step();
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(bus.cmpt_cnt[W*ch +: W]);
  endfunction

  initial begin
    idle_inputs();
    // Reset held: random inputs must not disturb any output.
    for (int i = 0; i < 4; i++) begin
      bus.tx_cmpt  = C'($urandom);
      bus.tx_ting  = C'($urandom);
      bus.txb_full = C'($urandom);
      bus.rxb_full = C'($urandom);
      bus.rxb_empty = C'($urandom);
      bus.irq_en   = 8'($urandom);
      step();
    end
    check_vec("rst_state", bus.state, 32'h0);
    check_vec("rst_cnt", 32'(bus.cmpt_cnt), 32'h0);
    check_vec("rst_irq", 32'(bus.irq), 32'h0);
    idle_inputs();
    rst = 1'b1;
    step();
    check_vec("idle_state", bus.state, 32'h0);

    // Level bit: one-cycle latency.
    bus.txb_full[1] = 1'b1;
    #2;
    check_vec("lvl_before_edge", 32'(bus.state[11]), 32'h0);
    step();
    check_vec("lvl_after_edge", bus.state, 32'h0000_0800);
    bus.txb_full[1] = 1'b0;
    step();

    // ch2 completion held 3 cycles, irq enabled for ch2 cmpt.
    bus.irq_en = 8'h10;
    bus.tx_cmpt[2] = 1'b1;
    step();
    check_vec("ch2_cmpt_s", 32'(bus.state[16]), 32'h1);
    check_vec("ch2_cnt1", cnt(2), 32'd1);
    check_vec("ch2_irq_lat", 32'(bus.irq), 32'h0);
    step();
    check_vec("ch2_irq", 32'(bus.irq), 32'h1);
    step();
    check_vec("ch2_held_one_evt", cnt(2), 32'd1);
    check_vec("ch2_no_ovr", 32'(bus.state[23]), 32'h0);
    bus.tx_cmpt[2] = 1'b0;
    step();
    bus.sticky_clr = 4'b0100;
    step();
    bus.sticky_clr = 4'b0000;
    check_vec("ch2_clr_bit", 32'(bus.state[16]), 32'h0);
    check_vec("ch2_irq_still", 32'(bus.irq), 32'h1);
    check_vec("ch2_cnt_kept", cnt(2), 32'd1);
    step();
    check_vec("ch2_irq_clr", 32'(bus.irq), 32'h0);
    bus.irq_en = 8'h00;

    // ch0 overrun, then edge coinciding with a clear.
    pulse(0);
    pulse(0);
    check_vec("ch0_ovr", 32'(bus.state[7:0]), 32'h81);
    check_vec("ch0_cnt2", cnt(0), 32'd2);
    bus.tx_cmpt[0] = 1'b1;
    bus.sticky_clr[0] = 1'b1;
    step();
    bus.tx_cmpt[0] = 1'b0;
    bus.sticky_clr[0] = 1'b0;
    check_vec("ch0_set_wins", 32'(bus.state[7:0]), 32'h01);
    check_vec("ch0_cnt3", cnt(0), 32'd3);
    step();

    // ch3 saturation at 7, then clear+edge and plain clear.
    for (int i = 0; i < 9; i++) pulse(3);
    check_vec("ch3_sat", cnt(3), 32'd7);
    bus.tx_cmpt[3] = 1'b1;
    bus.cnt_clr[3] = 1'b1;
    step();
    bus.tx_cmpt[3] = 1'b0;
    check_vec("ch3_clr_edge", cnt(3), 32'd1);
    step();
    bus.cnt_clr[3] = 1'b0;
    check_vec("ch3_clr", cnt(3), 32'd0);

    // ch1 rxb_full edge with irq_en[3].
    bus.irq_en = 8'h08;
    bus.rxb_full[1] = 1'b1;
    bus.rxb_empty[1] = 1'b0;
    step();
    check_vec("ch1_rx_bits", 32'(bus.state[15:8]), 32'h70);
    check_vec("ch1_irq_lat", 32'(bus.irq), 32'h0);
    step();
    check_vec("ch1_irq", 32'(bus.irq), 32'h1);
    bus.sticky_clr[1] = 1'b1;
    step();
    bus.sticky_clr[1] = 1'b0;
    step();
    check_vec("ch1_no_reset", 32'(bus.state[15:8]), 32'h30);
    check_vec("ch1_irq_clr", 32'(bus.irq), 32'h0);

    // irq_en change: ch0 cmpt_s is still pending.
    bus.irq_en = 8'h01;
    step();
    check_vec("en_change_irq", 32'(bus.irq), 32'h1);

    // Asynchronous reset mid-cycle.
    check_vec("pre_rst_cnt0", cnt(0), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check_vec("arst_state", bus.state, 32'h0);
    check_vec("arst_cnt", 32'(bus.cmpt_cnt), 32'h0);
    check_vec("arst_irq", 32'(bus.irq), 32'h0);
    bus.tx_cmpt[0] = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check_vec("first_clk_edge", cnt(0), 32'd1);
    check_vec("first_clk_sticky", 32'(bus.state[0]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
